// File: rtl/write_seq_pkg.sv
// rtl/write_seq_pkg.sv - shared state type and destination codes for the write-enable sequencer
package write_seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } seq_state_e;

   localparam int CODE_NONE = 0;

   // Default register-bank map; code k drives write-enable bit k-1.
   localparam int CODE_PC = 1;
   localparam int CODE_DR = 2;
   localparam int CODE_R1 = 3;
   localparam int CODE_R2 = 4;
   localparam int CODE_R3 = 5;
   localparam int CODE_R4 = 6;
   localparam int CODE_R5 = 7;
   localparam int CODE_TR = 8;

endpackage

// File: rtl/wr_onehot_dec.sv
// rtl/wr_onehot_dec.sv - gated destination-code to one-hot write-enable decoder
module wr_onehot_dec #(
   parameter int SEL_W    = 4,
   parameter int NUM_DEST = 8
) (
   input  logic                en,
   input  logic [SEL_W-1:0]    code,
   output logic [NUM_DEST-1:0] onehot
);

   // Code 0 and codes above NUM_DEST match no bit, so they decode to zero.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_DEST; i++) begin
         onehot[i] = en && (code == SEL_W'(i + 1));
      end
   end

endmodule

// File: rtl/write_en_sequencer.sv
// rtl/write_en_sequencer.sv - handshake-driven one-hot write-enable sequencer with wrapping bursts
module write_en_sequencer
   import write_seq_pkg::*;
#(
   parameter int NUM_DEST = 8,
   parameter int SEL_W    = 4,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sel_valid,
   output logic                sel_ready,
   input  logic [SEL_W-1:0]    sel_code,
   input  logic [CNT_W-1:0]    burst_len,
   input  logic                hold,
   output logic [NUM_DEST-1:0] wr_en,
   output logic [SEL_W-1:0]    wr_code,
   output logic                busy,
   output logic                done,
   output logic                err
);

   seq_state_e       state;
   logic [SEL_W-1:0] cur_code;
   logic [CNT_W-1:0] remaining;
   logic             err_q;
   logic             accept;
   logic             advance;
   logic             last_beat;

   assign accept    = sel_valid && sel_ready;
   assign advance   = (state == WRITE) && !hold;
   assign last_beat = (remaining == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_code  <= '0;
         remaining <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && (sel_code != SEL_W'(CODE_NONE))) begin
                  if (sel_code > SEL_W'(NUM_DEST)) begin
                     err_q <= 1'b1;
                  end else begin
                     state     <= WRITE;
                     cur_code  <= sel_code;
                     remaining <= (burst_len == '0) ? CNT_W'(1) : burst_len;
                  end
               end
            end
            WRITE: begin
               if (!hold) begin
                  if (last_beat) begin
                     // Clearing cur_code keeps wr_code at zero while idle.
                     state     <= IDLE;
                     cur_code  <= '0;
                     remaining <= '0;
                  end else begin
                     cur_code  <= (cur_code == SEL_W'(NUM_DEST)) ? SEL_W'(1) : cur_code + SEL_W'(1);
                     remaining <= remaining - CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sel_ready = (state == IDLE);
   assign busy      = (state == WRITE);
   assign wr_code   = cur_code;
   assign done      = advance && last_beat;
   assign err       = err_q;

   wr_onehot_dec #(
      .SEL_W    (SEL_W),
      .NUM_DEST (NUM_DEST)
   ) u_dec (
      .en     (advance),
      .code   (cur_code),
      .onehot (wr_en)
   );

endmodule

// File: doc/write_en_sequencer.md
Name: write_en_sequencer

Overview:
Parametrised successor to the fixed 8-destination write-enable decoder in the down-sampler datapath controller. It accepts a destination code over a valid/ready handshake and drives one-hot register write enables. It supports burst writes to consecutive destinations with wrap-around, stall via hold, illegal-code detection and completion pulses. It sits between the control FSM and the register bank (PC, DR, R1..R5, TR in the default configuration).

Parameters:
NUM_DEST, 8, number of writable destinations; code k (1..NUM_DEST) selects destination bit k-1 (default map: 1=PC, 2=DR, 3..7=R1..R5, 8=TR)
SEL_W, 4, destination code width; must satisfy 2**SEL_W > NUM_DEST
CNT_W, 4, burst length field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
sel_valid  in  1  request valid
sel_ready  out  1  block can accept a request
sel_code  in  SEL_W  destination code; 0 = no write
burst_len  in  CNT_W  consecutive destinations to write; 0 is treated as 1
hold  in  1  stall; freezes the sequence
wr_en  out  NUM_DEST  one-hot write enable, at most one bit high
wr_code  out  SEL_W  code currently being written (0 when idle)
busy  out  1  burst in progress
done  out  1  one-cycle pulse coinciding with the last wr_en of a burst
err  out  1  one-cycle pulse when an illegal code is received

Behaviour:
- Reset: state IDLE; cur_code=0, remaining=0; wr_en=0, wr_code=0, busy=0, done=0, err=0; sel_ready=1 from the first cycle after reset deasserts.
- States: IDLE, WRITE.
- sel_ready = (state==IDLE). A request is accepted on an edge where sel_valid && sel_ready.
- IDLE, accepted code 0: no state change, no outputs asserted.
- IDLE, accepted code > NUM_DEST: err=1 on the next cycle only; no writes; stays IDLE.
- IDLE, accepted legal code: on the next edge go to WRITE with cur_code=sel_code and remaining=max(burst_len,1).
- WRITE outputs: wr_en = onehot(cur_code-1) when !hold, else 0. wr_code=cur_code. busy=1.
- WRITE with !hold on each edge:
  - cur_code increments; after NUM_DEST it wraps to 1.
  - remaining decrements.
  - When remaining==1 in the current cycle, done=1 in that cycle and the next state is IDLE.
- WRITE with hold=1: wr_en=0, done=0, cur_code and remaining frozen, busy stays 1.
- Latency:
  - Accept at edge N gives the first wr_en in cycle N+1.
  - A burst of L with no hold occupies exactly L cycles.
  - The earliest next accept is in the first IDLE cycle, so back-to-back requests have a one-cycle gap.
- burst_len > NUM_DEST is legal; destinations repeat via wrap.
- sel_code and burst_len are ignored while in WRITE.
- Reset mid-burst: the burst is abandoned; all outputs are zero from the next cycle and no done pulse is produced.
- Outputs wr_en, done and busy are functions of the state registers and hold only; there is no combinational path from sel_* to any output except sel_ready, which depends on state only.

Decomposition:
- Shared package write_seq_pkg holds:
  - the state enum (IDLE, WRITE);
  - CODE_NONE=0;
  - default destination code constants (CODE_PC=1, CODE_DR=2, CODE_R1=3 .. CODE_R5=7, CODE_TR=8).
- One sub-module, wr_onehot_dec: parametrised combinational code-to-one-hot decoder (SEL_W, NUM_DEST). Its enable input gates all bits; codes 0 or > NUM_DEST give zero.

Test Plan:
- Single write: reset, then sel_code=2, burst_len=1, valid for 1 cycle -> next cycle wr_en=8'b0000_0010, wr_code=2, done=1; following cycle idle with sel_ready=1.
- Burst with wrap: sel_code=7, burst_len=3 -> wr_en 8'h40, 8'h80, 8'h01 on three consecutive cycles; done only with 8'h01.
- Hold mid-burst: sel_code=3, burst_len=4, hold=1 during the 2nd write cycle for 2 cycles -> wr_en sequence 04, 00, 00, 08, 10, 20; busy held throughout; done with 20.
- Illegal and null codes: sel_code=9 -> err pulse 1 cycle, wr_en=0, sel_ready stays 1; sel_code=0 -> no err, no wr_en.
- Reset mid-burst: sel_code=1, burst_len=8, rst asserted at 3rd write cycle -> next cycle wr_en=0, busy=0, no done; a new request is accepted after rst deasserts.
- burst_len=0 and ignored inputs: sel_code=5, burst_len=0 -> exactly one write (8'h10). Changing sel_code during a burst of 3 does not alter the sequence.
